serial_word_feeder: RTL
=======================

// Module: serial_word_feeder
// PURPOSE
//   Parallel-to-serial front end for the serial multiple-of-three detector.
//   - Accepts a WIDTH-bit word over a valid/ready handshake.
//   - Emits the word MSB-first, one bit per clock, on ser_bit/ser_valid.
//   - Pulses frame_clr for one cycle before the first bit so the downstream
//     detector restarts from its initial state on every word.
// PARAMETERS
//   WIDTH       8  bits per word, >=1
//   GAP_CYCLES  1  idle cycles after the last bit before the next accept, >=0
// PORTS
//   clk         in   1      system clock; all logic is on the rising edge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      upstream word valid
//   in_data     in   WIDTH  upstream word
//   in_ready    out  1      feeder can accept; a transfer is in_valid && in_ready
//   ser_bit     out  1      serial data, MSB first; 0 when ser_valid=0
//   ser_valid   out  1      ser_bit carries a payload bit this cycle
//   frame_clr   out  1      one-cycle restart pulse, intended for the detector rst
//   frame_last  out  1      high with the final (LSB) bit of a word
//   busy        out  1      high in any state other than IDLE
//   ref_mult3   out  1      present only with MOD3_REF_EN (see CONFIGURATION)
// BEHAVIOUR
//   - All outputs are registered. States: IDLE, CLR, SHIFT, GAP.
//   - Reset
//     - rst high: next edge forces IDLE and clears all outputs to 0.
//       in_ready is 0 while rst=1 and rises in the first cycle after rst falls.
//     - rst mid-word abandons the word. No further ser_valid; no partial resume.
//   - IDLE: in_ready=1. On transfer, latch in_data into the shift register
//     and go to CLR.
//   - CLR (1 cycle): frame_clr=1, ser_valid=0. Load bit counter = WIDTH-1.
//     Go to SHIFT.
//   - SHIFT (WIDTH cycles)
//     - ser_valid=1, ser_bit=sreg[WIDTH-1]. Shift left each cycle; counter
//       decrements.
//     - frame_last=1 when counter==0. After that cycle, go to GAP, or to IDLE
//       if GAP_CYCLES==0.
//   - GAP: GAP_CYCLES cycles with all outputs 0 except busy, then IDLE.
//   - Timing: transfer at edge N -> frame_clr in cycle N+1 -> first bit in
//     cycle N+2 -> last bit in cycle N+1+WIDTH.
//   - Throughput: one word per WIDTH+2+GAP_CYCLES cycles.
//   - in_valid while in_ready=0 is ignored; the latched word is never altered
//     mid-frame. Upstream holds in_data until the transfer.
//   - WIDTH=1: the SHIFT state lasts one cycle, with frame_last=1 and ser_valid=1.
// CONFIGURATION
//   - MOD3_REF_EN defined
//     - Builds a golden remainder tracker r[1:0], cleared to 0 in CLR.
//     - Each SHIFT cycle: r <= (2*r + ser_bit) mod 3.
//     - ref_mult3 is registered (r_next==0). In the cycle after bit k it reflects
//       the prefix through bit k, the same timing as the detector's registered
//       output.
//     - ref_mult3 is 1 at reset and in CLR, since the empty prefix is 0.
//   - MOD3_REF_EN undefined: no tracker logic and no ref_mult3 port.
//   - All other behaviour is identical in both builds.
// STRUCTURE
//   - ser_feed_pkg: state encoding localparams ST_IDLE/ST_CLR/ST_SHIFT/ST_GAP,
//     the remainder width, and a counter-width function clog2(WIDTH).
//   - Sub-module mod3_ref_tracker (clk, rst, clr, bit_valid, bit_in, mult3).
//     It is instantiated only under MOD3_REF_EN.
//   - Top level holds the FSM, shift register, bit counter and gap counter.
// TESTING
//   1 Reset
//     - Stimulus: rst=1 for 2 cycles, then 0.
//     - Response: in_ready=0 and ser_valid/frame_clr=0 during reset;
//       in_ready=1 in the first cycle after.
//   2 Single word
//     - Stimulus: 8'h5A (90).
//     - Response: one frame_clr, then bits 0,1,0,1,1,0,1,0 on 8 consecutive
//       cycles with frame_last on the 8th.
//     - Response: ref_mult3 = 1,0,0,0,0,0,1,1 (prefixes 0,1,2,5,11,22,45,90).
//   3 Back-to-back words
//     - Stimulus: in_valid held high with 8'hFF, then 8'h07.
//     - Response: second transfer exactly 11 cycles after the first
//       (WIDTH+2+GAP).
//     - Response: final ref_mult3 is 1 for 8'hFF and 0 for 8'h07.
//   4 Reset mid-word
//     - Stimulus: rst asserted after the 3rd bit of 8'hA5.
//     - Response: no further ser_valid; the next word begins with frame_clr and
//       its own MSB.
//   5 Busy hazard
//     - Stimulus: in_data changes to 8'h00 with in_valid=1 during SHIFT of
//       8'hC3.
//     - Response: serial stream is still 1,1,0,0,0,0,1,1; 8'h00 is accepted only
//       at the next IDLE.
//   6 Minimum config
//     - Stimulus: WIDTH=1, GAP_CYCLES=0, words 1 then 0.
//     - Response: frames every 3 cycles; ser_bit 1 then 0, each with frame_last=1.

Source files
------------

// File: rtl/ser_feed_pkg.sv
// Shared definitions for the serial word feeder: FSM state encoding, the
// remainder width of the mod-3 reference tracker, and small helper functions.
// Optional feature macro used by the feeder: MOD3_REF_EN.
package ser_feed_pkg;

  // Feeder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLR   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // A remainder modulo 3 needs two bits.
  localparam int REM_W = 2;

  // Counter width able to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // One step of the MSB-first remainder recurrence: (2*r + b) mod 3.
  function automatic logic [REM_W-1:0] mod3_step(input logic [REM_W-1:0] r,
                                                 input logic b);
    logic [2:0] sum;
    sum = {r, 1'b0} + {2'b00, b};
    return (sum >= 3'd3) ? REM_W'(sum - 3'd3) : REM_W'(sum);
  endfunction

endpackage

// File: rtl/mod3_ref_tracker.sv
// Golden remainder tracker: follows the running value of an MSB-first bit
// stream modulo 3 and flags when the prefix seen so far is a multiple of 3.
// Only instantiated by serial_word_feeder when MOD3_REF_EN is defined.
module mod3_ref_tracker
  import ser_feed_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic mult3
);

  logic [REM_W-1:0] r;
  logic [REM_W-1:0] r_next;

  // Remainder after absorbing the current bit.
  always_comb begin
    r_next = mod3_step(r, bit_in);
  end

  // Remainder register and registered multiple-of-3 flag; the empty prefix is 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r     <= '0;
      mult3 <= 1'b1;
    end else if (bit_valid) begin
      r     <= r_next;
      mult3 <= (r_next == '0);
    end
  end

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for a serial multiple-of-three detector.
// Accepts a word over valid/ready, pulses frame_clr, then emits the word
// MSB first on ser_bit/ser_valid, followed by GAP_CYCLES idle cycles.
// All outputs are registered: each is computed from the next state.
// Define MOD3_REF_EN to add the golden remainder tracker and ref_mult3 port.
module serial_word_feeder
  import ser_feed_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             frame_clr,
  output logic             frame_last,
  output logic             busy
`ifdef MOD3_REF_EN
  ,
  output logic             ref_mult3
`endif
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int GAP_W = clog2(GAP_CYCLES);

  state_t           state, state_next;
  logic [WIDTH-1:0] sreg, sreg_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [GAP_W-1:0] gap, gap_next;

  logic in_ready_next, ser_bit_next, ser_valid_next;
  logic frame_clr_next, frame_last_next, busy_next;

  // Next-state, datapath and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb infers a latch.
    state_next      = state;
    sreg_next       = sreg;
    cnt_next        = cnt;
    gap_next        = gap;
    ser_bit_next    = 1'b0;
    ser_valid_next  = 1'b0;
    frame_clr_next  = 1'b0;
    frame_last_next = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_next     = ST_CLR;
          sreg_next      = in_data;
          frame_clr_next = 1'b1;
        end
      end
      ST_CLR: begin
        // Present the MSB as the shift phase opens.
        state_next      = ST_SHIFT;
        cnt_next        = CNT_W'(WIDTH - 1);
        ser_valid_next  = 1'b1;
        ser_bit_next    = sreg[WIDTH-1];
        sreg_next       = sreg << 1;
        frame_last_next = (WIDTH == 1);
      end
      ST_SHIFT: begin
        if (cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_GAP;
            gap_next   = GAP_W'(GAP_CYCLES - 1);
          end
        end else begin
          cnt_next        = cnt - 1'b1;
          ser_valid_next  = 1'b1;
          ser_bit_next    = sreg[WIDTH-1];
          sreg_next       = sreg << 1;
          frame_last_next = (cnt == CNT_W'(1));
        end
      end
      ST_GAP: begin
        if (gap == '0) state_next = ST_IDLE;
        else           gap_next   = gap - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase

    in_ready_next = (state_next == ST_IDLE);
    busy_next     = (state_next != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      gap        <= '0;
      in_ready   <= 1'b0;
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      frame_clr  <= 1'b0;
      frame_last <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sreg       <= sreg_next;
      cnt        <= cnt_next;
      gap        <= gap_next;
      in_ready   <= in_ready_next;
      ser_bit    <= ser_bit_next;
      ser_valid  <= ser_valid_next;
      frame_clr  <= frame_clr_next;
      frame_last <= frame_last_next;
      busy       <= busy_next;
    end
  end

`ifdef MOD3_REF_EN
  // Clear the tracker on the accept edge so ref_mult3 already reads 1 in CLR.
  logic tracker_clr;
  assign tracker_clr = (state_next == ST_CLR);

  mod3_ref_tracker u_ref (
    .clk       (clk),
    .rst       (rst),
    .clr       (tracker_clr),
    .bit_valid (ser_valid),
    .bit_in    (ser_bit),
    .mult3     (ref_mult3)
  );
`endif

endmodule
